// File: rtl/mmio_timer_pkg.sv
// Register map offsets, CTRL field positions and decode types shared by the timer and the bus decode.
// Offsets are byte offsets from the window base; all registers are 32-bit words.
package mmio_timer_pkg;

    localparam logic [31:0] OFF_MTIME  = 32'h00;
    localparam logic [31:0] OFF_MTIMEH = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_STATUS = 32'h0C;
    localparam logic [31:0] OFF_CMP0   = 32'h10;
    localparam logic [31:0] CMP_STRIDE = 32'h08;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_MASK_LSB     = 16;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MTIME,
        SEL_MTIMEH,
        SEL_CTRL,
        SEL_STATUS,
        SEL_CMP,
        SEL_CMPH
    } reg_sel_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescale divider: ticks once every (prescale+1) enabled cycles; tick is combinational from the count.
// No backpressure; clear restarts the period, disable freezes the count.
module mmio_timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk24,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_count;

    assign o_tick = i_en && (r_count == i_prescale);

    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tick ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, NUM_CMP compare channels, irq mask and MTIMEH snapshot.
// Read data one cycle after the address; mtip/irq registered; no backpressure, every access completes.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
    parameter int          NUM_CMP      = 2,
    parameter int          PRESCALE_W   = 8
) (
    input  logic               clk24,
    input  logic               rst_n,
    input  logic [31:0]        address,
    input  logic [3:0]         write_sections,
    input  logic [31:0]        write_value,
    input  logic               read_strobe,
    output logic [31:0]        read_value,
    output logic               read_hit,
    output logic [NUM_CMP-1:0] mtip,
    output logic               irq
);

    localparam int          CH_W    = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1;
    localparam logic [31:0] WIN_END = OFF_CMP0 + CMP_STRIDE * 32'(NUM_CMP);

    logic [63:0]           r_mtime;
    logic [31:0]           r_snap;
    logic                  r_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [NUM_CMP-1:0]    r_mask;
    logic [31:0]           r_read_value;
    logic                  r_read_hit;
    logic [NUM_CMP-1:0]    r_mtip;
    logic                  r_irq;

    logic [31:0]           w_word_off;
    logic [31:0]           w_cmp_off;
    logic [CH_W-1:0]       w_ch;
    reg_sel_e              w_sel;
    logic                  w_wr;
    logic                  w_tick;
    logic [31:0]           w_ctrl_rd;
    logic [31:0]           w_ctrl_wr;
    logic [31:0]           w_rd_dat;
    logic [63:0]           w_mtime_nxt;
    logic [63:0]           w_cmp [NUM_CMP];
    logic [NUM_CMP-1:0]    w_hit;
    logic                  w_unused;

    // Subtraction wraps addresses below the base to huge offsets, so one bound check covers both sides.
    assign w_word_off = {address[31:2], 2'b00} - BASE_ADDRESS;
    assign w_cmp_off  = w_word_off - OFF_CMP0;
    assign w_ch       = w_cmp_off[3 +: CH_W];
    assign w_wr       = |write_sections;
    assign w_unused   = &{1'b0, address[1:0], w_cmp_off, w_ctrl_wr};

    always_comb begin
        w_sel = SEL_NONE;
        if (w_word_off < WIN_END) begin
            case (w_word_off)
                OFF_MTIME:  w_sel = SEL_MTIME;
                OFF_MTIMEH: w_sel = SEL_MTIMEH;
                OFF_CTRL:   w_sel = SEL_CTRL;
                OFF_STATUS: w_sel = SEL_STATUS;
                default:    w_sel = w_cmp_off[2] ? SEL_CMPH : SEL_CMP;
            endcase
        end
    end

    always_comb begin
        w_ctrl_rd                                 = '0;
        w_ctrl_rd[CTRL_EN_BIT]                    = r_en;
        w_ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_W] = r_prescale;
        w_ctrl_rd[CTRL_MASK_LSB +: NUM_CMP]       = r_mask;
    end

    assign w_ctrl_wr = byte_merge(w_ctrl_rd, write_value, write_sections);

    always_comb begin
        w_rd_dat = '0;
        case (w_sel)
            SEL_MTIME:  w_rd_dat = r_mtime[31:0];
            SEL_MTIMEH: w_rd_dat = r_snap;
            SEL_CTRL:   w_rd_dat = w_ctrl_rd;
            SEL_STATUS: w_rd_dat[NUM_CMP-1:0] = r_mtip;
            SEL_CMP:    w_rd_dat = w_cmp[w_ch][31:0];
            SEL_CMPH:   w_rd_dat = w_cmp[w_ch][63:32];
            default:    w_rd_dat = '0;
        endcase
    end

    // A software write to either half holds the whole counter for that cycle.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr && w_sel == SEL_MTIME) begin
            w_mtime_nxt[31:0] = byte_merge(r_mtime[31:0], write_value, write_sections);
        end else if (w_wr && w_sel == SEL_MTIMEH) begin
            w_mtime_nxt[63:32] = byte_merge(r_mtime[63:32], write_value, write_sections);
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    mmio_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk24      (clk24),
        .rst_n      (rst_n),
        .i_en       (r_en),
        .i_clear    (w_wr && w_sel == SEL_CTRL),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    for (genvar g = 0; g < NUM_CMP; g++) begin : g_cmp
        logic [63:0] r_cmp;
        logic        w_ch_wr;

        assign w_ch_wr  = w_wr && (w_ch == CH_W'(g));
        assign w_cmp[g] = r_cmp;
        assign w_hit[g] = (r_mtime >= r_cmp);

        always_ff @(posedge clk24) begin
            if (!rst_n) begin
                r_cmp <= '1;
            end else if (w_ch_wr && w_sel == SEL_CMP) begin
                r_cmp[31:0] <= byte_merge(r_cmp[31:0], write_value, write_sections);
            end else if (w_ch_wr && w_sel == SEL_CMPH) begin
                r_cmp[63:32] <= byte_merge(r_cmp[63:32], write_value, write_sections);
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            r_mtime      <= '0;
            r_snap       <= '0;
            r_en         <= 1'b1;
            r_prescale   <= '0;
            r_mask       <= '0;
            r_read_value <= '0;
            r_read_hit   <= 1'b0;
            r_mtip       <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_mtime <= w_mtime_nxt;
            if (read_strobe && w_sel == SEL_MTIME) begin
                r_snap <= r_mtime[63:32];
            end
            if (w_wr && w_sel == SEL_CTRL) begin
                r_en       <= w_ctrl_wr[CTRL_EN_BIT];
                r_prescale <= w_ctrl_wr[CTRL_PRESCALE_LSB +: PRESCALE_W];
                r_mask     <= w_ctrl_wr[CTRL_MASK_LSB +: NUM_CMP];
            end
            r_read_value <= w_rd_dat;
            r_read_hit   <= (w_sel != SEL_NONE);
            r_mtip       <= w_hit;
            r_irq        <= |(r_mtip & r_mask);
        end
    end

    assign read_value = r_read_value;
    assign read_hit   = r_read_hit;
    assign mtip       = r_mtip;
    assign irq        = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: one task per feature, hand-computed expectations.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] A_MTIME = 32'h00, A_MTIMEH = 32'h04, A_CTRL = 32'h08, A_STATUS = 32'h0C;
    localparam logic [31:0] A_CMP0 = 32'h10, A_CMP1 = 32'h18, A_CMPH1 = 32'h1C, A_IDLE = 32'h100;

    logic        clk24 = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = BASE + A_IDLE;
    logic [3:0]  write_sections = 4'h0;
    logic [31:0] write_value = '0;
    logic        read_strobe = 1'b0;
    logic [31:0] read_value;
    logic        read_hit;
    logic [1:0]  mtip;
    logic        irq;

    int errors = 0;
    int checks = 0;

    mmio_timer #(
        .BASE_ADDRESS (BASE),
        .NUM_CMP      (2),
        .PRESCALE_W   (8)
    ) dut (
        .clk24          (clk24),
        .rst_n          (rst_n),
        .address        (address),
        .write_sections (write_sections),
        .write_value    (write_value),
        .read_strobe    (read_strobe),
        .read_value     (read_value),
        .read_hit       (read_hit),
        .mtip           (mtip),
        .irq            (irq)
    );

    always #5 clk24 = ~clk24;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus cycle: inputs held across the next rising edge, outputs sampled 1 time unit after it.
    task automatic cyc(input logic [31:0] off, input logic [3:0] be, input logic [31:0] wv, input logic strobe);
        address        = BASE + off;
        write_sections = be;
        write_value    = wv;
        read_strobe    = strobe;
        @(posedge clk24);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] v);
        cyc(off, 4'hF, v, 1'b0);
    endtask

    task automatic rd(input logic [31:0] off, input logic strobe);
        cyc(off, 4'h0, 32'h0, strobe);
    endtask

    task automatic idle();
        cyc(A_IDLE, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        checks++; if (read_value !== 32'h0) begin errors++; $display("FAIL reset_read_value: got %h expected 0", read_value); end
        checks++; if (read_hit !== 1'b0) begin errors++; $display("FAIL reset_read_hit: got %b expected 0", read_hit); end
        checks++; if (mtip !== 2'b00) begin errors++; $display("FAIL reset_mtip: got %b expected 00", mtip); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst_n = 1'b1;
        rd(A_CMP0, 1'b0);
        chk32("reset_cmp0", read_value, 32'hFFFF_FFFF);
        checks++; if (read_hit !== 1'b1) begin errors++; $display("FAIL reset_cmp0_hit: got %b expected 1", read_hit); end
        rd(A_CTRL, 1'b0);
        chk32("reset_ctrl", read_value, 32'h0000_0001);
        rd(A_STATUS, 1'b0);
        chk32("reset_status", read_value, 32'h0);
    endtask

    task automatic test_ctrl_fields();
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, 1'b0);
        chk32("ctrl_all_ones", read_value, 32'h0003_FF01);
        wr(A_CTRL, 32'h0000_0001);
        cyc(A_CTRL, 4'b0010, 32'hFFFF_05FF, 1'b0);
        rd(A_CTRL, 1'b0);
        chk32("ctrl_byte_lane", read_value, 32'h0000_0501);
        wr(A_CTRL, 32'h0000_0001);
    endtask

    task automatic test_count();
        logic [31:0] v [20];
        wr(A_CTRL, 32'h0000_0300);
        wr(A_MTIME, 32'h0);
        wr(A_MTIMEH, 32'h0);
        wr(A_CTRL, 32'h0000_0301);
        for (int k = 1; k <= 13; k++) begin
            rd(A_MTIME, 1'b0);
            v[k] = read_value;
        end
        wr(A_CTRL, 32'h0000_0301);
        for (int k = 15; k <= 19; k++) begin
            rd(A_MTIME, 1'b0);
            v[k] = read_value;
        end
        chk32("count_c4", v[4], 32'd0);
        chk32("count_c5", v[5], 32'd1);
        chk32("count_c9", v[9], 32'd2);
        chk32("count_c13", v[13], 32'd3);
        chk32("count_restart_c17", v[17], 32'd3);
        chk32("count_restart_c19", v[19], 32'd4);
    endtask

    task automatic test_snapshot();
        wr(A_CTRL, 32'h0);
        wr(A_MTIME, 32'hFFFF_FFFE);
        wr(A_MTIMEH, 32'h1);
        wr(A_CTRL, 32'h1);
        rd(A_MTIME, 1'b1);
        chk32("snap_lo", read_value, 32'hFFFF_FFFE);
        repeat (5) idle();
        rd(A_MTIMEH, 1'b0);
        chk32("snap_hi_held", read_value, 32'h1);
        rd(A_MTIME, 1'b0);
        chk32("snap_lo_live", read_value, 32'h5);
        rd(A_MTIMEH, 1'b0);
        chk32("snap_no_strobe", read_value, 32'h1);
        rd(A_MTIME, 1'b1);
        chk32("snap_lo2", read_value, 32'h7);
        rd(A_MTIMEH, 1'b0);
        chk32("snap_hi_new", read_value, 32'h2);
    endtask

    task automatic test_byte_write();
        wr(A_CTRL, 32'h0);
        wr(A_MTIME, 32'h0000_00FF);
        wr(A_MTIMEH, 32'h0);
        wr(A_CTRL, 32'h1);
        cyc(A_MTIME, 4'b0010, 32'h0000_AB00, 1'b0);
        chk32("bw_prewrite_read", read_value, 32'h0000_00FF);
        rd(A_MTIME, 1'b0);
        chk32("bw_merged_no_inc", read_value, 32'h0000_ABFF);
        rd(A_MTIME, 1'b1);
        chk32("bw_resumed", read_value, 32'h0000_AC00);
        rd(A_MTIMEH, 1'b0);
        chk32("bw_hi", read_value, 32'h0);
    endtask

    task automatic test_compare_irq();
        wr(A_CTRL, 32'h0);
        wr(A_MTIME, 32'h0);
        wr(A_MTIMEH, 32'h0);
        wr(A_CMP1, 32'd10);
        wr(A_CMPH1, 32'h0);
        idle();
        idle();
        checks++; if (mtip !== 2'b00) begin errors++; $display("FAIL cmp_idle_mtip: got %b expected 00", mtip); end
        wr(A_CTRL, 32'h0002_0001);
        repeat (10) idle();
        checks++; if (mtip !== 2'b00 || irq !== 1'b0) begin errors++; $display("FAIL cmp_before: got mtip=%b irq=%b expected 00/0", mtip, irq); end
        idle();
        checks++; if (mtip !== 2'b10) begin errors++; $display("FAIL cmp_rise: got %b expected 10", mtip); end
        idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cmp_irq: got %b expected 1", irq); end
        rd(A_STATUS, 1'b0);
        chk32("cmp_status", read_value, 32'h2);
        wr(A_CMP1, 32'd100);
        checks++; if (mtip !== 2'b10) begin errors++; $display("FAIL cmp_fall_n1: got %b expected 10", mtip); end
        idle();
        checks++; if (mtip !== 2'b00) begin errors++; $display("FAIL cmp_fall_n2: got %b expected 00", mtip); end
        idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cmp_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_wrap_decode();
        wr(A_CTRL, 32'h0);
        wr(A_MTIME, 32'hFFFF_FFFF);
        wr(A_MTIMEH, 32'hFFFF_FFFF);
        idle();
        idle();
        checks++; if (mtip !== 2'b11) begin errors++; $display("FAIL wrap_max_mtip: got %b expected 11", mtip); end
        wr(A_CTRL, 32'h1);
        idle();
        checks++; if (mtip !== 2'b11) begin errors++; $display("FAIL wrap_mtip_n1: got %b expected 11", mtip); end
        idle();
        checks++; if (mtip !== 2'b00) begin errors++; $display("FAIL wrap_mtip_clear: got %b expected 00", mtip); end
        rd(A_MTIME, 1'b1);
        chk32("wrap_lo", read_value, 32'h1);
        rd(A_MTIMEH, 1'b0);
        chk32("wrap_hi", read_value, 32'h0);
        rd(32'h20, 1'b0);
        checks++; if (read_hit !== 1'b0 || read_value !== 32'h0) begin errors++; $display("FAIL decode_past_end: got hit=%b val=%h expected 0/0", read_hit, read_value); end
        rd(32'hFFFF_FFFC, 1'b0);
        checks++; if (read_hit !== 1'b0 || read_value !== 32'h0) begin errors++; $display("FAIL decode_below_base: got hit=%b val=%h expected 0/0", read_hit, read_value); end
    endtask

    initial begin
        test_reset();
        test_ctrl_fields();
        test_count();
        test_snapshot();
        test_byte_write();
        test_compare_irq();
        test_wrap_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
